// File: rtl/uart_rx_fifo_stat_if.sv
// Signal bundle between the UART byte assembler / DSP read port and the RX FIFO.
// The master modport drives the stimulus side; the slave modport is the FIFO.
interface uart_rx_fifo_stat_if;
    logic       RX_WR;
    logic [7:0] RX_DATA;
    logic       RX_PERR;
    logic       RX_FERR;
    logic       RD_POP;
    logic       FIFO_CLR;
    logic       ERR_CLR;
    logic       CHAR_TICK;
    logic [7:0] RD_DATA;
    logic       RxFIFO_Empty;
    logic       RxFIFO_L2_Full;
    logic       RxFIFO_L4_Full;
    logic       RxFIFO_L8_Full;
    logic       RxFIFO_L12_Full;
    logic       RxFIFO_L14_Full;
    logic       RxFIFO_Full;
    logic       OverrunError;
    logic       ParityError;
    logic       FrameError;
    logic       RxTimeOut;

    modport master (
        output RX_WR, RX_DATA, RX_PERR, RX_FERR, RD_POP, FIFO_CLR, ERR_CLR, CHAR_TICK,
        input  RD_DATA, RxFIFO_Empty, RxFIFO_L2_Full, RxFIFO_L4_Full, RxFIFO_L8_Full,
               RxFIFO_L12_Full, RxFIFO_L14_Full, RxFIFO_Full, OverrunError,
               ParityError, FrameError, RxTimeOut
    );

    modport slave (
        input  RX_WR, RX_DATA, RX_PERR, RX_FERR, RD_POP, FIFO_CLR, ERR_CLR, CHAR_TICK,
        output RD_DATA, RxFIFO_Empty, RxFIFO_L2_Full, RxFIFO_L4_Full, RxFIFO_L8_Full,
               RxFIFO_L12_Full, RxFIFO_L14_Full, RxFIFO_Full, OverrunError,
               ParityError, FrameError, RxTimeOut
    );
endinterface

// File: rtl/uart_rx_fifo_stat.sv
// UART receive FIFO with level thresholds, sticky overrun and character-time RX timeout.
// Define UART_RX_ERR_TAG_EN to store per-byte parity/framing tags alongside the data.
module uart_rx_fifo_stat #(
    parameter int DEPTH    = 16,
    parameter int TO_CHARS = 4
) (
    input  logic               DSP_CLK,
    input  logic               RESETn,
    uart_rx_fifo_stat_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TO_CHARS + 1);
    localparam int THR [5] = '{2, 4, 8, 12, 14};

`ifdef UART_RX_ERR_TAG_EN
    localparam int EW = 10;
`else
    localparam int EW = 8;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] entry;
    logic [EW-1:0] head;

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0] level_reg, level_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          empty_reg, full_reg, overrun_reg;
    logic [4:0]    lx_reg, lx_next;
    logic          do_push, do_pop, overrun_set;

    // A pop while full frees the slot the simultaneous push needs, so no overrun then.
    always_comb begin
        do_pop      = bus.RD_POP && !empty_reg;
        do_push     = bus.RX_WR && (!full_reg || do_pop);
        overrun_set = bus.RX_WR && full_reg && !bus.RD_POP;
        wr_ptr_next = wr_ptr_reg + AW'(do_push);
        rd_ptr_next = rd_ptr_reg + AW'(do_pop);
        level_next  = level_reg + LW'(do_push) - LW'(do_pop);
        if (bus.FIFO_CLR) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (do_push || do_pop || bus.FIFO_CLR || empty_reg)
            cnt_next = '0;
        else if (bus.CHAR_TICK && cnt_reg != CW'(TO_CHARS))
            cnt_next = cnt_reg + CW'(1);
    end

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_thr
            assign lx_next[gi] = (level_next >= LW'(THR[gi]));
        end
    endgenerate

    always_ff @(posedge DSP_CLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            level_reg   <= '0;
            cnt_reg     <= '0;
            empty_reg   <= 1'b1;
            full_reg    <= 1'b0;
            lx_reg      <= '0;
            overrun_reg <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            level_reg   <= level_next;
            cnt_reg     <= cnt_next;
            empty_reg   <= (level_next == '0);
            full_reg    <= (level_next == LW'(DEPTH));
            lx_reg      <= lx_next;
            if (overrun_set)
                overrun_reg <= 1'b1;
            else if (bus.ERR_CLR)
                overrun_reg <= 1'b0;
        end
    end

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge DSP_CLK) begin
        if (do_push && !bus.FIFO_CLR)
            mem[wr_ptr_reg] <= entry;
    end

    assign head = mem[rd_ptr_reg];

`ifdef UART_RX_ERR_TAG_EN
    assign entry           = {bus.RX_FERR, bus.RX_PERR, bus.RX_DATA};
    assign bus.ParityError = !empty_reg && head[8];
    assign bus.FrameError  = !empty_reg && head[9];
`else
    logic unused_tags;
    assign entry           = bus.RX_DATA;
    assign unused_tags     = bus.RX_PERR ^ bus.RX_FERR;
    assign bus.ParityError = 1'b0;
    assign bus.FrameError  = 1'b0;
`endif

    assign bus.RD_DATA         = empty_reg ? 8'h00 : head[7:0];
    assign bus.RxFIFO_Empty    = empty_reg;
    assign bus.RxFIFO_L2_Full  = lx_reg[0];
    assign bus.RxFIFO_L4_Full  = lx_reg[1];
    assign bus.RxFIFO_L8_Full  = lx_reg[2];
    assign bus.RxFIFO_L12_Full = lx_reg[3];
    assign bus.RxFIFO_L14_Full = lx_reg[4];
    assign bus.RxFIFO_Full     = full_reg;
    assign bus.OverrunError    = overrun_reg;
    assign bus.RxTimeOut       = (cnt_reg == CW'(TO_CHARS)) && !empty_reg;
endmodule
